// File: rtl/core_pkg.sv
// Shared definitions for the core sequencer and the decode logic around it:
// phase encoding, FPU wait limit default and small decode helpers.
package core_pkg;

    localparam int STATE_W             = 3;
    localparam int FPU_TIMEOUT_DEFAULT = 255;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WRITE  = 3'd4,
        ST_IDLE   = 3'd5,
        ST_HALT   = 3'd6
    } core_state_e;

    // An instruction needs the MEM phase for any data-memory or I/O access.
    function automatic logic needs_mem_phase(input logic mem_read, input logic mem_write,
                                             input logic data_in, input logic data_out);
        return mem_read | mem_write | data_in | data_out;
    endfunction

    // Branch target selected for unconditional branches or taken conditional ones.
    function automatic logic branch_taken(input logic branch_c, input logic branch_uc,
                                          input logic cond);
        return branch_uc | (branch_c & cond);
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Handshake and strobe bundle between the sequencer and the rest of the core.
//
// Handshakes: a requester holds its request/valid (imem_req, dmem_req,
// io_tx_valid) high until the cycle the partner's ready/ack (imem_ready,
// dmem_ack, io_tx_ready) is sampled high; the transfer happens in that cycle.
// io_rx_valid is held by the source and consumed by a one-cycle io_rx_ack.
// fpu_start is a single-cycle launch, fpu_done is the completion indication.
// instret_ld/instret_wdata let the core overwrite the retired-instruction counter.
interface core_sequencer_if;
    logic        imem_req;
    logic        imem_ready;
    logic        ir_we;
    logic        use_fpu;
    logic        mem_read;
    logic        mem_write;
    logic        data_in;
    logic        data_out;
    logic        reg_write;
    logic        writef;
    logic        branch_c;
    logic        branch_uc;
    logic        cond;
    logic        fpu_start;
    logic        fpu_done;
    logic        dmem_req;
    logic        dmem_ack;
    logic        io_rx_valid;
    logic        io_rx_ack;
    logic        io_tx_valid;
    logic        io_tx_ready;
    logic        rf_we;
    logic        frf_we;
    logic        pc_we;
    logic        pc_sel;
    logic        instret_ld;
    logic [31:0] instret_wdata;

    modport master (
        output imem_req, ir_we, fpu_start, dmem_req, io_rx_ack, io_tx_valid,
               rf_we, frf_we, pc_we, pc_sel,
        input  imem_ready, use_fpu, mem_read, mem_write, data_in, data_out,
               reg_write, writef, branch_c, branch_uc, cond, fpu_done, dmem_ack,
               io_rx_valid, io_tx_ready, instret_ld, instret_wdata
    );

    modport slave (
        input  imem_req, ir_we, fpu_start, dmem_req, io_rx_ack, io_tx_valid,
               rf_we, frf_we, pc_we, pc_sel,
        output imem_ready, use_fpu, mem_read, mem_write, data_in, data_out,
               reg_write, writef, branch_c, branch_uc, cond, fpu_done, dmem_ack,
               io_rx_valid, io_tx_ready, instret_ld, instret_wdata
    );

endinterface

// File: rtl/wait_timer.sv
// EXEC wait counter: cleared by start, advanced by tick. expired flags the
// tick that completes LIMIT waited cycles, so the caller leaves EXEC after
// exactly LIMIT cycles without a completion.
module wait_timer
    import core_pkg::*;
#(
    parameter int LIMIT = FPU_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic tick,
    output logic expired
);

    localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

    logic [W-1:0] count_q;

    // Count waited cycles; start wins over tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (start) begin
            count_q <= '0;
        end else if (tick) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = tick && (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH, DECODE, EXEC (with optional FPU
// wait), MEM (data memory then I/O) and WRITE, with IDLE when not running and
// an absorbing HALT after an FPU timeout.
module core_sequencer
    import core_pkg::*;
#(
    parameter int FPU_TIMEOUT = FPU_TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    output logic [STATE_W-1:0]    state,
    output logic [31:0]           instret,
    output logic                  err,
    core_sequencer_if.master      bus
);

    core_state_e state_q;
    core_state_e state_d;

    logic        rst_seen_q;    // one edge seen since reset release
    logic        exec_first_q;  // current cycle is the first EXEC cycle
    logic        din_q;         // data_in captured in the first EXEC cycle
    logic        dout_q;        // data_out captured in the first EXEC cycle
    logic        mem_done_q;    // memory part of MEM finished
    logic        rx_done_q;     // input-byte part of MEM finished
    logic [31:0] instret_q;
    logic        err_q;

    logic din_eff;
    logic dout_eff;
    logic mem_pend;
    logic rx_pend;
    logic tx_pend;
    logic timer_start;
    logic timer_tick;
    logic timer_expired;

    // In the first EXEC cycle the latches are not loaded yet, so use the live bits.
    assign din_eff  = exec_first_q ? bus.data_in  : din_q;
    assign dout_eff = exec_first_q ? bus.data_out : dout_q;

    assign mem_pend = (bus.mem_read | bus.mem_write) & ~mem_done_q;
    assign rx_pend  = din_q & ~rx_done_q;
    assign tx_pend  = dout_q;

    assign timer_start = (state_q == ST_DECODE);
    assign timer_tick  = (state_q == ST_EXEC) & bus.use_fpu & ~bus.fpu_done;

    wait_timer #(.LIMIT(FPU_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (timer_start),
        .tick    (timer_tick),
        .expired (timer_expired)
    );

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Phase transitions.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (run && rst_seen_q) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.imem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (!bus.use_fpu || bus.fpu_done) begin
                    state_d = needs_mem_phase(bus.mem_read, bus.mem_write, din_eff, dout_eff)
                              ? ST_MEM : ST_WRITE;
                end else if (timer_expired) begin
                    state_d = ST_HALT;
                end
            end
            ST_MEM: begin
                if (mem_pend) begin
                    if (bus.dmem_ack && !din_q && !dout_q) state_d = ST_WRITE;
                end else if (rx_pend) begin
                    if (bus.io_rx_valid && !dout_q) state_d = ST_WRITE;
                end else if (!tx_pend || bus.io_tx_ready) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Requests and strobes decoded from the current phase.
    always_comb begin
        bus.imem_req    = 1'b0;
        bus.ir_we       = 1'b0;
        bus.fpu_start   = 1'b0;
        bus.dmem_req    = 1'b0;
        bus.io_rx_ack   = 1'b0;
        bus.io_tx_valid = 1'b0;
        bus.rf_we       = 1'b0;
        bus.frf_we      = 1'b0;
        bus.pc_we       = 1'b0;
        bus.pc_sel      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                bus.imem_req = 1'b1;
                bus.ir_we    = bus.imem_ready;
            end
            ST_EXEC: begin
                bus.fpu_start = bus.use_fpu & exec_first_q;
            end
            ST_MEM: begin
                bus.dmem_req    = mem_pend;
                bus.io_rx_ack   = ~mem_pend & rx_pend & bus.io_rx_valid;
                bus.io_tx_valid = ~mem_pend & ~rx_pend & tx_pend;
            end
            ST_WRITE: begin
                bus.pc_we  = 1'b1;
                bus.rf_we  = bus.reg_write & ~bus.writef;
                bus.frf_we = bus.writef;
                bus.pc_sel = branch_taken(bus.branch_c, bus.branch_uc, bus.cond);
            end
            default: begin
            end
        endcase
    end

    // Latches, MEM sub-phase progress, retired count and the sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_seen_q   <= 1'b0;
            exec_first_q <= 1'b0;
            din_q        <= 1'b0;
            dout_q       <= 1'b0;
            mem_done_q   <= 1'b0;
            rx_done_q    <= 1'b0;
            instret_q    <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            rst_seen_q   <= 1'b1;
            exec_first_q <= (state_q == ST_DECODE);
            if ((state_q == ST_EXEC) && exec_first_q) begin
                din_q  <= bus.data_in;
                dout_q <= bus.data_out;
            end
            if (state_q == ST_MEM) begin
                if (mem_pend && bus.dmem_ack) mem_done_q <= 1'b1;
                if (!mem_pend && rx_pend && bus.io_rx_valid) rx_done_q <= 1'b1;
            end else begin
                mem_done_q <= 1'b0;
                rx_done_q  <= 1'b0;
            end
            if (bus.instret_ld) begin
                instret_q <= bus.instret_wdata;
            end else if (state_q == ST_WRITE) begin
                instret_q <= instret_q + 32'd1;
            end
            if (state_d == ST_HALT) err_q <= 1'b1;
        end
    end

    assign state   = state_q;
    assign instret = instret_q;
    assign err     = err_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Testbench for core_sequencer: directed scenarios plus randomized
// instructions, each checked against per-instruction expectations computed
// from phase lengths and handshake delays.
module tb_core_sequencer;
    import core_pkg::*;

    localparam int TO = FPU_TIMEOUT_DEFAULT;

    typedef struct {
        bit use_fpu;
        bit mem_rd;
        bit mem_wr;
        bit din;
        bit dout;
        bit rw;
        bit wf;
        bit bc;
        bit bu;
        bit cnd;
        bit drop_run;
        int fd;   // cycles before imem_ready
        int pd;   // cycles after fpu_start before fpu_done
        int md;   // cycles before dmem_ack
        int rd;   // cycles before io_rx_valid
        int td;   // cycles before io_tx_ready
    } instr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [2:0]  state;
    logic [31:0] instret;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_instret = 32'd0;
    logic [31:0] exp_q[$];

    core_sequencer_if bus();

    core_sequencer #(.FPU_TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .state   (state),
        .instret (instret),
        .err     (err),
        .bus     (bus)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic logic [8:0] strobes();
        return {bus.imem_req, bus.ir_we, bus.fpu_start, bus.dmem_req, bus.io_rx_ack,
                bus.io_tx_valid, bus.rf_we, bus.frf_we, bus.pc_we};
    endfunction

    task automatic clear_inputs();
        bus.imem_ready    = 1'b0;
        bus.use_fpu       = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.data_in       = 1'b0;
        bus.data_out      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.writef        = 1'b0;
        bus.branch_c      = 1'b0;
        bus.branch_uc     = 1'b0;
        bus.cond          = 1'b0;
        bus.fpu_done      = 1'b0;
        bus.dmem_ack      = 1'b0;
        bus.io_rx_valid   = 1'b0;
        bus.io_tx_ready   = 1'b0;
        bus.instret_ld    = 1'b0;
        bus.instret_wdata = 32'd0;
    endtask

    // driver + monitor for one instruction; entered and left at a negedge
    task automatic run_instr(input instr_t in, input string tag);
        int cnt[16];
        int expv[16];
        string nm[16];
        int mem_len, rx_len, tx_len, cyc;
        bit done;
        logic [2:0] st;
        logic [2:0] exp_next;
        logic [31:0] exp_ir;

        nm = '{"fetch_cycles", "decode_cycles", "exec_cycles", "mem_cycles", "write_cycles",
               "total_cycles", "ir_we", "fpu_start", "dmem_req", "io_rx_ack", "io_tx_valid",
               "pc_we", "rf_we", "frf_we", "pc_sel", "strobe_overlap"};
        for (int k = 0; k < 16; k++) cnt[k] = 0;

        mem_len = (in.mem_rd || in.mem_wr) ? in.md + 1 : 0;
        rx_len  = in.din  ? in.rd + 1 : 0;
        tx_len  = in.dout ? in.td + 1 : 0;

        // expectations derived from phase lengths
        expv[0]  = in.fd + 1;
        expv[1]  = 1;
        expv[2]  = in.use_fpu ? in.pd + 1 : 1;
        expv[3]  = mem_len + rx_len + tx_len;
        expv[4]  = 1;
        expv[5]  = expv[0] + expv[1] + expv[2] + expv[3] + expv[4];
        expv[6]  = 1;
        expv[7]  = in.use_fpu ? 1 : 0;
        expv[8]  = mem_len;
        expv[9]  = in.din ? 1 : 0;
        expv[10] = tx_len;
        expv[11] = 1;
        expv[12] = (in.rw && !in.wf) ? 1 : 0;
        expv[13] = in.wf ? 1 : 0;
        expv[14] = (in.bu || (in.bc && in.cnd)) ? 1 : 0;
        expv[15] = 0;
        exp_next = in.drop_run ? 3'd5 : 3'd0;
        exp_instret = exp_instret + 32'd1;
        exp_q.push_back(exp_instret);

        bus.use_fpu   = in.use_fpu;
        bus.mem_read  = in.mem_rd;
        bus.mem_write = in.mem_wr;
        bus.reg_write = in.rw;
        bus.writef    = in.wf;
        bus.branch_c  = in.bc;
        bus.branch_uc = in.bu;
        bus.cond      = in.cnd;
        run = 1'b1;

        done = 1'b0;
        cyc = 0;
        while (!done && cyc < 2000) begin
            st = state;
            bus.imem_ready  = (st == 3'd0) && (cnt[0] == in.fd);
            bus.fpu_done    = (st == 3'd2) && in.use_fpu && (cnt[2] == in.pd);
            bus.data_in     = ((st == 3'd2) && (cnt[2] == 0)) ? in.din  : ~in.din;
            bus.data_out    = ((st == 3'd2) && (cnt[2] == 0)) ? in.dout : ~in.dout;
            bus.dmem_ack    = (st == 3'd3) && (mem_len > 0) && (cnt[3] == mem_len - 1);
            bus.io_rx_valid = (st == 3'd3) && (rx_len > 0) && (cnt[3] == mem_len + rx_len - 1);
            bus.io_tx_ready = (st == 3'd3) && (tx_len > 0) &&
                              (cnt[3] == mem_len + rx_len + tx_len - 1);
            if ((st == 3'd2) && (cnt[2] == 0) && in.drop_run) run = 1'b0;
            #1;
            cnt[6]  += int'(bus.ir_we);
            cnt[7]  += int'(bus.fpu_start);
            cnt[8]  += int'(bus.dmem_req);
            cnt[9]  += int'(bus.io_rx_ack);
            cnt[10] += int'(bus.io_tx_valid);
            cnt[11] += int'(bus.pc_we);
            cnt[12] += int'(bus.rf_we);
            cnt[13] += int'(bus.frf_we);
            cnt[14] += int'(bus.pc_we && bus.pc_sel);
            if (int'(bus.ir_we) + int'(bus.fpu_start) + int'(bus.io_rx_ack) + int'(bus.pc_we) > 1)
                cnt[15]++;
            case (st)
                3'd0: cnt[0]++;
                3'd1: cnt[1]++;
                3'd2: cnt[2]++;
                3'd3: cnt[3]++;
                3'd4: begin cnt[4]++; done = 1'b1; end
                default: ;
            endcase
            cyc++;
            @(negedge clk);
        end
        cnt[5] = cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4];

        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s retire_timeout: no WRITE within %0d cycles (state %0d)", tag, cyc, state);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (cnt[k] !== expv[k]) begin
                errors++;
                $display("FAIL %s %s: got %0d expected %0d", tag, nm[k], cnt[k], expv[k]);
            end
        end
        checks++;
        if (state !== exp_next) begin
            errors++;
            $display("FAIL %s next_state: got %0d expected %0d", tag, state, exp_next);
        end
        exp_ir = exp_q.pop_front();
        checks++;
        if (instret !== exp_ir) begin
            errors++;
            $display("FAIL %s instret: got %h expected %h", tag, instret, exp_ir);
        end
    endtask

    function automatic instr_t blank_instr();
        instr_t r;
        r = '{default: 0};
        return r;
    endfunction

    task automatic test_reset();
        clear_inputs();
        run = 1'b1;
        rst_n = 1'b0;
        exp_instret = 32'd0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        checks++;
        if (state !== 3'd5) begin errors++; $display("FAIL reset_state: got %0d expected 5", state); end
        checks++;
        if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %h expected 0", instret); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++;
        if (strobes() !== 9'd0) begin errors++; $display("FAIL reset_strobes: got %b expected 0", strobes()); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 3'd5) begin errors++; $display("FAIL first_edge_state: got %0d expected 5", state); end
        @(negedge clk);
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL second_edge_state: got %0d expected 0", state); end
    endtask

    task automatic test_alu();
        instr_t i;
        i = blank_instr();
        i.rw = 1'b1;
        run_instr(i, "alu");
    endtask

    task automatic test_fpu();
        instr_t i;
        i = blank_instr();
        i.use_fpu = 1'b1;
        i.wf = 1'b1;
        i.rw = 1'b1;
        i.pd = 5;
        run_instr(i, "fpu");
        i.pd = 0;
        i.wf = 1'b0;
        run_instr(i, "fpu_done_at_start");
    endtask

    task automatic test_mem_read();
        instr_t i;
        i = blank_instr();
        i.mem_rd = 1'b1;
        i.rw = 1'b1;
        i.md = 3;
        i.fd = 2;
        run_instr(i, "mem_read");
    endtask

    task automatic test_data_out();
        instr_t i;
        i = blank_instr();
        i.dout = 1'b1;
        i.td = 10;
        run_instr(i, "data_out");
        i = blank_instr();
        i.din = 1'b1;
        i.rd = 2;
        run_instr(i, "data_in");
    endtask

    task automatic test_mem_and_io();
        instr_t i;
        i = blank_instr();
        i.mem_wr = 1'b1;
        i.din = 1'b1;
        i.dout = 1'b1;
        i.md = 1;
        i.rd = 2;
        i.td = 3;
        i.use_fpu = 1'b1;
        i.pd = 2;
        run_instr(i, "mem_and_io");
    endtask

    task automatic test_branch_run_drop();
        instr_t i;
        i = blank_instr();
        i.bc = 1'b1;
        i.cnd = 1'b1;
        i.drop_run = 1'b1;
        i.mem_rd = 1'b1;
        i.md = 1;
        run_instr(i, "branch_run_drop");
        i = blank_instr();
        i.bc = 1'b1;
        i.cnd = 1'b0;
        run_instr(i, "branch_not_taken");
    endtask

    task automatic test_wrap();
        instr_t i;
        bus.imem_ready = 1'b0;
        bus.instret_ld = 1'b1;
        bus.instret_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.instret_ld = 1'b0;
        checks++;
        if (instret !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL instret_load: got %h expected ffffffff", instret);
        end
        exp_instret = 32'hFFFF_FFFF;
        i = blank_instr();
        i.bu = 1'b1;
        run_instr(i, "wrap");
    endtask

    task automatic test_back_to_back();
        instr_t i;
        for (int n = 0; n < 40; n++) begin
            i.use_fpu  = 1'($urandom_range(0, 1));
            i.mem_rd   = 1'($urandom_range(0, 1));
            i.mem_wr   = 1'($urandom_range(0, 3) == 0);
            i.din      = 1'($urandom_range(0, 2) == 0);
            i.dout     = 1'($urandom_range(0, 2) == 0);
            i.rw       = 1'($urandom_range(0, 1));
            i.wf       = 1'($urandom_range(0, 1));
            i.bc       = 1'($urandom_range(0, 1));
            i.bu       = 1'($urandom_range(0, 3) == 0);
            i.cnd      = 1'($urandom_range(0, 1));
            i.drop_run = 1'($urandom_range(0, 5) == 0);
            i.fd       = int'($urandom_range(0, 3));
            i.pd       = int'($urandom_range(0, 7));
            i.md       = int'($urandom_range(0, 4));
            i.rd       = int'($urandom_range(0, 4));
            i.td       = int'($urandom_range(0, 4));
            run_instr(i, "random");
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int ecyc;
        int bad;
        clear_inputs();
        bus.use_fpu = 1'b1;
        bus.reg_write = 1'b1;
        run = 1'b1;
        cyc = 0;
        ecyc = 0;
        while (ecyc < 3 && cyc < 200) begin
            bus.imem_ready = (state == 3'd0);
            if (state == 3'd2) ecyc++;
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (ecyc != 3) begin errors++; $display("FAIL reset_mid_reach_exec: got %0d expected 3", ecyc); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 3'd5) begin errors++; $display("FAIL reset_mid_state: got %0d expected 5", state); end
        checks++;
        if (instret !== 32'd0) begin errors++; $display("FAIL reset_mid_instret: got %h expected 0", instret); end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.pc_we || bus.rf_we) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_mid_no_retire: got %0d expected 0", bad); end
        rst_n = 1'b1;
        exp_instret = 32'd0;
        exp_q.delete();
    endtask

    task automatic test_timeout();
        int cyc;
        int ecyc;
        int early;
        int bad;
        clear_inputs();
        bus.use_fpu = 1'b1;
        run = 1'b1;
        cyc = 0;
        ecyc = 0;
        early = 0;
        while (state !== 3'd6 && cyc < 1000) begin
            bus.imem_ready = (state == 3'd0);
            if (state == 3'd2) begin
                ecyc++;
                if (err) early++;
            end
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (state !== 3'd6) begin errors++; $display("FAIL timeout_halt: got state %0d expected 6", state); end
        checks++;
        if (ecyc != TO) begin errors++; $display("FAIL timeout_exec_cycles: got %0d expected %0d", ecyc, TO); end
        checks++;
        if (early != 0) begin errors++; $display("FAIL timeout_err_early: got %0d expected 0", early); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", err); end
        bad = 0;
        repeat (6) begin
            bus.imem_ready  = 1'($urandom_range(0, 1));
            bus.fpu_done    = 1'b1;
            bus.dmem_ack    = 1'($urandom_range(0, 1));
            bus.io_rx_valid = 1'($urandom_range(0, 1));
            bus.io_tx_ready = 1'($urandom_range(0, 1));
            bus.data_in     = 1'($urandom_range(0, 1));
            bus.reg_write   = 1'b1;
            #1;
            if (state !== 3'd6 || strobes() !== 9'd0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL halt_absorbing: got %0d bad cycles expected 0", bad); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL halt_reset_err: got %b expected 0", err); end
        checks++;
        if (state !== 3'd5) begin errors++; $display("FAIL halt_reset_state: got %0d expected 5", state); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_alu();
        test_fpu();
        test_mem_read();
        test_data_out();
        test_mem_and_io();
        test_branch_run_drop();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter: FPU_TIMEOUT, default 255, max EXEC wait cycles for fpu_done.
REQ-003 Ports (name  direction  width  meaning):
  clk  in  1  core clock
  rst_n  in  1  async active-low reset
  run  in  1  permits fetching new instructions
  state  out  3  phase: FETCH=0 DECODE=1 EXEC=2 MEM=3 WRITE=4 IDLE=5 HALT=6
  imem_req  out  1  instruction fetch request
  imem_ready  in  1  instruction word valid
  ir_we  out  1  instruction register load pulse
  use_fpu, mem_read, mem_write, data_in, data_out, reg_write, writef, branch_c, branch_uc  in  1 each  decoded controls
  cond  in  1  ALU compare result bit
  fpu_start  out  1  FPU launch pulse
  fpu_done  in  1  FPU result valid
  dmem_req  out  1  data memory request, held
  dmem_ack  in  1  data memory complete
  io_rx_valid  in  1  input byte available
  io_rx_ack  out  1  input byte consumed pulse
  io_tx_valid  out  1  output byte valid, held
  io_tx_ready  in  1  output sink accepts
  rf_we, frf_we, pc_we  out  1 each  integer/float regfile and PC write pulses
  pc_sel  out  1  1 = branch target, 0 = PC+4, valid with pc_we
  instret  out  32  retired-instruction counter
  err  out  1  sticky FPU timeout flag

Function
REQ-004 IDLE: all strobes 0; run=1 -> FETCH next cycle.
REQ-005 FETCH: imem_req=1 until imem_ready; on the imem_ready cycle ir_we=1 for one cycle, -> DECODE.
REQ-006 DECODE: exactly one cycle, -> EXEC.
REQ-007 On the first EXEC cycle, data_in and data_out SHALL be latched internally, because they are valid only in that cycle; mem_read, mem_write, reg_write, writef and use_fpu are stable through WRITE and are used directly.
REQ-008 EXEC, use_fpu=0: one cycle.
REQ-009 EXEC, use_fpu=1: fpu_start=1 on the first EXEC cycle only; stay in EXEC until fpu_done=1, which is sampled from the first EXEC cycle onward, so done in the start cycle is legal and gives a 1-cycle EXEC.
REQ-010 EXEC wait counter: counts from 0 at EXEC entry; if the count reaches FPU_TIMEOUT with no fpu_done -> HALT and set err.
REQ-011 EXEC exit: mem_read|mem_write|latched data_in|latched data_out -> MEM, else -> WRITE.
REQ-012 MEM, memory access: dmem_req=1 until dmem_ack, then -> WRITE.
REQ-013 MEM, data_in: wait for io_rx_valid; io_rx_ack=1 for one cycle in that cycle, then -> WRITE.
REQ-014 MEM, data_out: io_tx_valid=1 until io_tx_ready, then -> WRITE.
REQ-015 MEM, simultaneous memory and I/O flags: the memory access completes first, then the I/O access.
REQ-016 WRITE: one cycle with pc_we=1, rf_we=reg_write&~writef, frf_we=writef, pc_sel=branch_uc|(branch_c&cond), and instret+1 (wraps 0xFFFFFFFF->0).
REQ-017 WRITE exit: run=1 -> FETCH, else -> IDLE; deasserting run mid-instruction never aborts the instruction.
REQ-018 HALT is absorbing until reset; all strobes are 0 in HALT.
REQ-019 At most one of ir_we, fpu_start, io_rx_ack, pc_we SHALL be high in any cycle.

Reset
REQ-020 On rst_n=0 (asynchronous): state=IDLE, instret=0, err=0, all request/strobe outputs 0, wait counter and latches cleared.
REQ-021 Reset asserted mid-operation SHALL abandon the instruction with no pc_we/rf_we pulse.
REQ-022 The first FETCH occurs no earlier than the second clock edge after rst_n rises with run=1.

Structure
REQ-023 The state encoding constants and FPU_TIMEOUT default SHALL live in shared package core_pkg, also used by decode logic.
REQ-024 The EXEC wait counter and timeout compare SHALL be sub-module wait_timer (start, tick, expired); the rest is one FSM.

Verification
REQ-025 ALU op, run=1, imem_ready immediate -> states 0,1,2,4,0; one pc_we; instret=1; total 4 cycles.
REQ-026 use_fpu=1, fpu_done 5 cycles after fpu_start -> EXEC lasts 6 cycles, one fpu_start pulse, frf_we=1 in WRITE if writef=1.
REQ-027 mem_read=1, dmem_ack after 3 cycles -> dmem_req held 4 cycles, then WRITE with rf_we=1.
REQ-028 data_out=1 present only in first EXEC cycle, io_tx_ready delayed 10 cycles -> io_tx_valid held 11 cycles, then WRITE.
REQ-029 use_fpu=1, fpu_done never asserted -> HALT after FPU_TIMEOUT cycles, err=1; a reset pulse clears err and the block returns to IDLE.
REQ-030 branch_c=1, cond=1 -> pc_sel=1 with pc_we; run dropped during EXEC -> instruction retires, then IDLE; instret set to 0xFFFFFFFF -> wraps to 0.
